et_mux_2x1: RTL and testbench



---
 rtl/et_mux_pkg.sv | 9 +
 rtl/et_mux_dff.sv | 24 ++
 rtl/et_mux_2x1.sv | 67 ++++++
 tb/tb_et_mux_2x1.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/et_mux_pkg.sv
// Shared constants for the edge-triggered 2:1 mux cell: select encodings and default width.
package et_mux_pkg;

    localparam int   ET_MUX_DEFAULT_WIDTH = 1;

    localparam logic ET_MUX_SEL_A = 1'b0;
    localparam logic ET_MUX_SEL_B = 1'b1;

endpackage

// File: rtl/et_mux_dff.sv
// WIDTH-wide rising-edge register with synchronous active-high reset to RESET_VAL.
module et_mux_dff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/et_mux_2x1.sv
// Registered 2:1 mux: out takes a (sel=0) or b (sel=1) at each rising edge.
// Define ET_MUX_INPUT_REG_EN to register a/b/sel first, giving 2-clock latency.
module et_mux_2x1
    import et_mux_pkg::*;
#(
    parameter int               WIDTH     = ET_MUX_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_sel;
    logic [WIDTH-1:0] w_mux;

`ifdef ET_MUX_INPUT_REG_EN
    // Input stage clears to zero on reset, so the edge after reset yields a_q (0), not RESET_VAL.
    et_mux_dff #(.WIDTH(WIDTH), .RESET_VAL('0)) u_a_reg (
        .clk (clk),
        .rst (rst),
        .i_d (a),
        .o_q (w_a)
    );

    et_mux_dff #(.WIDTH(WIDTH), .RESET_VAL('0)) u_b_reg (
        .clk (clk),
        .rst (rst),
        .i_d (b),
        .o_q (w_b)
    );

    et_mux_dff #(.WIDTH(1), .RESET_VAL(ET_MUX_SEL_A)) u_sel_reg (
        .clk (clk),
        .rst (rst),
        .i_d (sel),
        .o_q (w_sel)
    );
`else
    assign w_a   = a;
    assign w_b   = b;
    assign w_sel = sel;
`endif

    // An unknown select deliberately propagates X rather than favouring either input.
    always_comb begin
        w_mux = 'x;
        case (w_sel)
            ET_MUX_SEL_A: w_mux = w_a;
            ET_MUX_SEL_B: w_mux = w_b;
            default:      w_mux = 'x;
        endcase
    end

    et_mux_dff #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_out_reg (
        .clk (clk),
        .rst (rst),
        .i_d (w_mux),
        .o_q (out)
    );

endmodule

// File: tb/tb_et_mux_2x1.sv
// Table-driven, scoreboarded bench for et_mux_2x1; adapts to ET_MUX_INPUT_REG_EN latency.
module tb_et_mux_2x1;

    localparam int           W  = 8;
    localparam logic [W-1:0] RV = 8'h00;
`ifdef ET_MUX_INPUT_REG_EN
    localparam int           LAT = 2;
`else
    localparam int           LAT = 1;
`endif

    typedef struct {
        logic         rst;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sel;
        logic [W-1:0] exp;
        string        name;
    } vec_t;

    typedef struct {
        int           due;
        logic [W-1:0] val;
        string        name;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sel = 1'b0;
    logic [W-1:0] a   = '0;
    logic [W-1:0] b   = '0;
    logic [W-1:0] out;

    sb_t          sbQ[$];
    vec_t         vecs[$];
    int           edgeCnt = 0;
    int           nChecks = 0;
    int           nFails  = 0;
    logic [W-1:0] lastExp = RV;

    et_mux_2x1 #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .sel (sel),
        .out (out)
    );

    always #5 clk = ~clk;

    function automatic void compare(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Inputs change on the falling edge; the expected value is queued for the edge it should appear at.
    task automatic applyStimulus(input logic r, input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic vs, input logic [W-1:0] exp, input string name);
        int k;
        @(negedge clk);
        rst = r;
        a   = va;
        b   = vb;
        sel = vs;
        k   = edgeCnt + 1;
        if (r) begin
            while (sbQ.size() > 0 && sbQ[$].due >= k) void'(sbQ.pop_back());
            sbQ.push_back('{due: k, val: exp, name: name});
            if (LAT == 2) sbQ.push_back('{due: k + 1, val: '0, name: {name, "_clr"}});
        end else begin
            sbQ.push_back('{due: k + LAT - 1, val: exp, name: name});
        end
    endtask

    task automatic checkOutput();
        sb_t e;
        while (sbQ.size() > 0 && sbQ[0].due < edgeCnt) begin
            e = sbQ.pop_front();
            nChecks++;
            nFails++;
            $display("[TB] FAIL %s_missed: got %h, expected %h at edge %0d", e.name, out, e.val, e.due);
        end
        if (sbQ.size() > 0 && sbQ[0].due == edgeCnt) begin
            e = sbQ.pop_front();
            compare(e.name, out, e.val);
            lastExp = e.val;
        end
    endtask

    task automatic checkStable(input string name);
        #1;
        compare(name, out, lastExp);
    endtask

    always begin
        @(posedge clk);
        edgeCnt++;
        #1;
        checkOutput();
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        vecs.push_back('{1'b1, 8'h01, 8'h01, 1'b1, RV,    "rst_edge1"});
        vecs.push_back('{1'b1, 8'h01, 8'h01, 1'b1, RV,    "rst_edge2"});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, "selA_00"});
        vecs.push_back('{1'b0, 8'h00, 8'hFF, 1'b0, 8'h00, "selA_01"});
        vecs.push_back('{1'b0, 8'hFF, 8'h00, 1'b0, 8'hFF, "selA_10"});
        vecs.push_back('{1'b0, 8'hFF, 8'hFF, 1'b0, 8'hFF, "selA_11"});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, "selB_00"});
        vecs.push_back('{1'b0, 8'h00, 8'hFF, 1'b1, 8'hFF, "selB_01"});
        vecs.push_back('{1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, "selB_10"});
        vecs.push_back('{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, "selB_11"});
        vecs.push_back('{1'b0, 8'hA5, 8'h3C, 1'b0, 8'hA5, "selA_pat"});
        vecs.push_back('{1'b0, 8'hA5, 8'h3C, 1'b1, 8'h3C, "selB_pat"});
        vecs.push_back('{1'b0, 8'h01, 8'h80, 1'b0, 8'h01, "selA_lsb"});
        vecs.push_back('{1'b0, 8'h01, 8'h80, 1'b1, 8'h80, "selB_msb"});
        vecs.push_back('{1'b0, 8'h00, 8'h01, 1'b1, 8'h01, "pre_rst_mid"});
        vecs.push_back('{1'b1, 8'h00, 8'h01, 1'b1, RV,    "rst_mid"});
        vecs.push_back('{1'b0, 8'h00, 8'h01, 1'b1, 8'h01, "post_rst_mid"});
        vecs.push_back('{1'b0, 8'h00, 8'h01, 1'b1, 8'h01, "post_rst_hold"});

        $display("[TB] Starting et_mux_2x1 test, latency %0d", LAT);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp, vecs[i].name);
        end

        // a changes mid-cycle: out must wait for the next rising edge.
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, "mid_a_pre1");
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, "mid_a_pre2");
        @(posedge clk);
        #3 a = 8'hFF;
        checkStable("stable_a_mid");
        applyStimulus(1'b0, 8'hFF, 8'h00, 1'b0, 8'hFF, "mid_a_edge");

        // sel toggles between edges with a=0, b=FF.
        applyStimulus(1'b0, 8'h00, 8'hFF, 1'b0, 8'h00, "tog_pre1");
        applyStimulus(1'b0, 8'h00, 8'hFF, 1'b0, 8'h00, "tog_pre2");
        @(posedge clk);
        #1 sel = 1'b1;
        checkStable("stable_sel_hi");
        #1 sel = 1'b0;
        checkStable("stable_sel_lo");
        applyStimulus(1'b0, 8'h00, 8'hFF, 1'b1, 8'hFF, "tog_edge");

        // rst raised between edges must not touch out until the edge.
        applyStimulus(1'b0, 8'h00, 8'hFF, 1'b1, 8'hFF, "rst_async_pre1");
        applyStimulus(1'b0, 8'h00, 8'hFF, 1'b1, 8'hFF, "rst_async_pre2");
        @(posedge clk);
        #2 rst = 1'b1;
        checkStable("stable_rst_mid");
        applyStimulus(1'b1, 8'h00, 8'hFF, 1'b1, RV,    "rst_async_edge");
        applyStimulus(1'b0, 8'h00, 8'hFF, 1'b1, 8'hFF, "rst_async_post");

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            applyStimulus(1'b0, ra, rb, rs, rs ? rb : ra, $sformatf("rand_%0d", i));
        end

        repeat (LAT + 1) @(posedge clk);
        #2;
        nChecks++;
        if (sbQ.size() != 0) begin
            nFails++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", sbQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
